sa_drain: RTL and testbench
===========================

SA_DRAIN -- requirements
Module: sa_drain

Interface
REQ-001 SHALL have parameter ARRAY_LENGTH, default 4, meaning the number of 32-bit result lanes per array row (1..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of buffered result rows (a power of 2, at least 2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port _res  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port SoutL  input  ARRAY_LENGTH*32  systolic-array result row; lane i is SoutL[i*32+31:i*32], signed two's complement.
REQ-006 SHALL have port Sready  input  1  row-valid strobe from the array; SoutL is valid on any rising edge where Sready=1.
REQ-007 SHALL have port m_data  output  32  current output lane.
REQ-008 SHALL have port m_valid  output  1  m_data is valid.
REQ-009 SHALL have port m_ready  input  1  consumer accepts m_data.
REQ-010 SHALL have port m_last  output  1  m_data is lane ARRAY_LENGTH-1 of its row.
REQ-011 SHALL have port full  output  1  all FIFO_DEPTH row slots are occupied.
REQ-012 SHALL have port overflow  output  1  sticky flag; a row was dropped.
REQ-013 SHALL have port count  output  clog2(FIFO_DEPTH)+1  number of rows held.

Function
REQ-014 SHALL capture SoutL into the tail row slot on a rising edge where Sready=1 and the write is accepted.
REQ-015 SHALL accept a write when full=0, or when full=1 and the final lane of the head row transfers on the same edge.
REQ-016 SHALL discard a row strobed while full=1 with no simultaneous head pop, leave the stored data unchanged, and set overflow=1 until reset.
REQ-017 SHALL drive m_valid=1 whenever count>0, and drive m_data from lane lane_idx of the head row.
REQ-018 SHALL perform a transfer on each rising edge where m_valid=1 and m_ready=1.
REQ-019 SHALL, on each transfer, increment lane_idx; on a transfer with lane_idx=ARRAY_LENGTH-1, wrap lane_idx to 0 and pop the head row.
REQ-020 SHALL drive m_last=1 exactly when m_valid=1 and lane_idx=ARRAY_LENGTH-1.
REQ-021 SHALL hold m_data, m_last and m_valid stable while m_valid=1 and m_ready=0.
REQ-022 SHALL raise m_valid on the cycle after the capturing edge when count was 0, giving 1-cycle latency from Sready to the first lane.
REQ-023 SHALL, on a simultaneous accepted write and head pop, leave count unchanged.
REQ-024 SHALL wrap the read and write row pointers modulo FIFO_DEPTH.
REQ-025 SHALL, when ARRAY_LENGTH=1, assert m_last on every valid beat and pop on every transfer.
REQ-026 SHALL ignore m_ready while m_valid=0; no state change.

Reset
REQ-027 SHALL, on a rising edge with _res=1, set count=0, both row pointers=0, lane_idx=0, overflow=0, m_valid=0, m_last=0, full=0 and m_data=0, regardless of Sready or m_ready.
REQ-028 SHALL discard any partially drained row on reset mid-operation; row slot contents need not be cleared.

Configuration
REQ-029 SHALL, with macro SA_DRAIN_RELU_EN defined, replace each lane with 0 at capture when its bit 31 is 1, and capture non-negative lanes unchanged.
REQ-030 SHALL, without SA_DRAIN_RELU_EN defined, capture all lanes unmodified.

Verification
REQ-031 SHALL cover single row: ARRAY_LENGTH=4, SoutL lanes {1,2,3,4}, one Sready pulse, m_ready=1 -> m_data 1,2,3,4 on 4 consecutive cycles starting 1 cycle after Sready; m_last only on 4; then m_valid=0 and count=0.
REQ-032 SHALL cover backpressure: one row captured, m_ready=0 for 5 cycles -> m_data=lane0 held, m_valid=1 held, count=1; release m_ready -> remaining beats in order.
REQ-033 SHALL cover overflow: FIFO_DEPTH=4, m_ready=0, 5 Sready pulses with rows tagged A..E -> full=1, count=4, overflow=1; draining yields rows A..D only.
REQ-034 SHALL cover simultaneous write and pop: full=1, last lane of the head row transfers on the same edge as Sready -> row accepted, overflow stays 0, count stays 4.
REQ-035 SHALL cover reset mid-drain: _res=1 while lane_idx=2 -> next cycle m_valid=0, count=0, overflow=0; a new row then drains from lane 0.
REQ-036 SHALL cover RELU: with SA_DRAIN_RELU_EN, lanes {-5, 7, 0x80000000, 0} -> output 0, 7, 0, 0; without the macro -> 0xFFFFFFFB, 7, 0x80000000, 0.

Source files
------------

// File: rtl/sa_drain.sv
// Drains systolic-array result rows into a row FIFO and streams them out one 32-bit lane per beat.
// Optional macro SA_DRAIN_RELU_EN clamps negative lanes to zero at capture.
module sa_drain #(
    parameter int ARRAY_LENGTH = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          _res,
    input  logic [ARRAY_LENGTH*32-1:0]    SoutL,
    input  logic                          Sready,
    output logic [31:0]                   m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = (ARRAY_LENGTH > 1) ? $clog2(ARRAY_LENGTH) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(ARRAY_LENGTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    logic [ARRAY_LENGTH*32-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              overflow_q, overflow_d;

    logic [ARRAY_LENGTH*32-1:0] cap_row;
    logic [ARRAY_LENGTH*32-1:0] head_row;
    logic [31:0]                head_lanes [ARRAY_LENGTH];
    logic                       xfer, pop, wr_accept, is_last;

    assign head_row = mem[rd_ptr_q];

    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_LENGTH; gi++) begin : g_lane
`ifdef SA_DRAIN_RELU_EN
            assign cap_row[gi*32 +: 32] = SoutL[gi*32+31] ? 32'd0 : SoutL[gi*32 +: 32];
`else
            assign cap_row[gi*32 +: 32] = SoutL[gi*32 +: 32];
`endif
            assign head_lanes[gi] = head_row[gi*32 +: 32];
        end
    endgenerate

    // A full FIFO still accepts a row when the head row's final lane leaves on the same edge.
    always_comb begin
        is_last    = (lane_q == LAST_LANE);
        xfer       = m_valid && m_ready;
        pop        = xfer && is_last;
        wr_accept  = Sready && (!full || pop);
        overflow_d = overflow_q || (Sready && full && !pop);
        wr_ptr_d   = wr_accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        lane_d     = lane_q;
        if (xfer) begin
            lane_d = is_last ? '0 : lane_q + LANE_W'(1);
        end
        count_d = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (_res) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lane_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lane_q     <= lane_d;
            overflow_q <= overflow_d;
        end
    end

    // Row storage is not reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (wr_accept && !_res) begin
            mem[wr_ptr_q] <= cap_row;
        end
    end

    always_comb begin
        m_valid  = (count_q != '0);
        m_last   = m_valid && is_last;
        m_data   = m_valid ? head_lanes[lane_q] : 32'd0;
        full     = (count_q == FULL_CNT);
        overflow = overflow_q;
        count    = count_q;
    end

endmodule

// File: tb/tb_sa_drain.sv
// Directed self-checking bench for sa_drain (ARRAY_LENGTH=4, FIFO_DEPTH=4).
module tb_sa_drain;

    localparam int AL = 4;
    localparam int FD = 4;

    logic              clk = 1'b0;
    logic              _res;
    logic [AL*32-1:0]  SoutL;
    logic              Sready;
    logic [31:0]       m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              full;
    logic              overflow;
    logic [2:0]        count;

    int checks_cnt = 0;
    int errors_cnt = 0;

    sa_drain #(.ARRAY_LENGTH(AL), .FIFO_DEPTH(FD)) dut (
        .clk      (clk),
        ._res     (_res),
        .SoutL    (SoutL),
        .Sready   (Sready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .full     (full),
        .overflow (overflow),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AL*32-1:0] make_row(input logic [31:0] base);
        logic [AL*32-1:0] r;
        for (int i = 0; i < AL; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    task automatic push_row(input logic [31:0] base);
        SoutL  = make_row(base);
        Sready = 1'b1;
        tick();
        Sready = 1'b0;
    endtask

    // Expects m_ready=1; checks each lane base+i and m_last, advancing one beat per lane.
    task automatic drain_row(input string tag, input logic [31:0] base);
        for (int i = 0; i < AL; i++) begin
            check_eq({tag, "_valid"}, 32'(m_valid), 32'd1);
            check_eq({tag, "_data"}, m_data, base + 32'(i));
            check_eq({tag, "_last"}, 32'(m_last), 32'(i == AL - 1));
            tick();
        end
    endtask

    task automatic do_reset();
        _res = 1'b1;
        tick();
        _res = 1'b0;
    endtask

    logic [31:0] relu_in  [AL];
    logic [31:0] relu_exp [AL];

    initial begin
        _res    = 1'b1;
        SoutL   = '0;
        Sready  = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        _res = 1'b0;

        check_eq("rst_valid", 32'(m_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_data", m_data, 32'd0);
        check_eq("rst_last", 32'(m_last), 32'd0);

        // Single row, first lane one cycle after the strobe.
        m_ready = 1'b1;
        push_row(32'd1);
        check_eq("single_count", 32'(count), 32'd1);
        drain_row("single", 32'd1);
        check_eq("single_empty_valid", 32'(m_valid), 32'd0);
        check_eq("single_empty_count", 32'(count), 32'd0);

        // Backpressure holds lane 0.
        m_ready = 1'b0;
        push_row(32'd10);
        for (int c = 0; c < 5; c++) begin
            check_eq("bp_data", m_data, 32'd10);
            check_eq("bp_valid", 32'(m_valid), 32'd1);
            check_eq("bp_last", 32'(m_last), 32'd0);
            check_eq("bp_count", 32'(count), 32'd1);
            tick();
        end
        m_ready = 1'b1;
        drain_row("bp", 32'd10);
        check_eq("bp_empty", 32'(m_valid), 32'd0);

        // Overflow: five rows into a four-row FIFO.
        m_ready = 1'b0;
        for (int r = 0; r < 4; r++) push_row(32'h0A00 + 32'(r) * 32'h100);
        check_eq("ovf_full4", 32'(full), 32'd1);
        check_eq("ovf_pre", 32'(overflow), 32'd0);
        push_row(32'h0E00);
        check_eq("ovf_full", 32'(full), 32'd1);
        check_eq("ovf_count", 32'(count), 32'd4);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        m_ready = 1'b1;
        for (int r = 0; r < 4; r++) drain_row("ovf_drain", 32'h0A00 + 32'(r) * 32'h100);
        check_eq("ovf_empty", 32'(m_valid), 32'd0);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-drain at lane 2.
        push_row(32'd20);
        tick();
        tick();
        check_eq("mid_lane2", m_data, 32'd22);
        do_reset();
        check_eq("mid_valid", 32'(m_valid), 32'd0);
        check_eq("mid_count", 32'(count), 32'd0);
        check_eq("mid_ovf", 32'(overflow), 32'd0);
        push_row(32'd30);
        drain_row("mid_new", 32'd30);

        // Write accepted while full because the head row pops on the same edge.
        m_ready = 1'b0;
        for (int r = 1; r <= 4; r++) push_row(32'(r) * 32'h1000);
        check_eq("sim_full", 32'(full), 32'd1);
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        check_eq("sim_last", 32'(m_last), 32'd1);
        push_row(32'h5000);
        check_eq("sim_count", 32'(count), 32'd4);
        check_eq("sim_ovf", 32'(overflow), 32'd0);
        check_eq("sim_full2", 32'(full), 32'd1);
        for (int r = 2; r <= 5; r++) drain_row("sim_drain", 32'(r) * 32'h1000);
        check_eq("sim_empty", 32'(count), 32'd0);

        // Negative-lane handling.
        relu_in[0] = -32'sd5;
        relu_in[1] = 32'd7;
        relu_in[2] = 32'h8000_0000;
        relu_in[3] = 32'd0;
`ifdef SA_DRAIN_RELU_EN
        relu_exp[0] = 32'd0;
        relu_exp[1] = 32'd7;
        relu_exp[2] = 32'd0;
        relu_exp[3] = 32'd0;
`else
        relu_exp[0] = 32'hFFFF_FFFB;
        relu_exp[1] = 32'd7;
        relu_exp[2] = 32'h8000_0000;
        relu_exp[3] = 32'd0;
`endif
        for (int i = 0; i < AL; i++) SoutL[i*32 +: 32] = relu_in[i];
        Sready = 1'b1;
        tick();
        Sready = 1'b0;
        for (int i = 0; i < AL; i++) begin
            check_eq("relu_data", m_data, relu_exp[i]);
            tick();
        end
        check_eq("relu_empty", 32'(m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
